iic_cfg_seq: RTL and testbench
==============================

IIC_CFG_SEQ -- requirements
Module: iic_cfg_seq

Interface
REQ-001 Parameter DEV_ID, default 8'hA0, 8-bit write address of the target device.
REQ-002 Parameter ADDR16, default 1, 1 = 16-bit register address, 0 = 8-bit.
REQ-003 Parameter PWR_DLY, default 1000, clk cycles of settle delay before the first write.
REQ-004 Parameter RETRY_MAX, default 3, retries per entry after a failed first attempt.
REQ-005 Parameter TIMEOUT, default 65535, maximum clk cycles to wait for wr_done.
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst_n  in  1  reset; asynchronous, active-low.
REQ-008 start  in  1  one-cycle pulse that launches the table walk.
REQ-009 tbl_len  in  8  number of table entries; sampled when start is accepted.
REQ-010 tbl_addr  out  8  table index driven to an external synchronous ROM.
REQ-011 tbl_data  in  24  ROM word {reg_addr[15:0], data[7:0]}; valid 1 cycle after tbl_addr.
REQ-012 w_req  out  1  one-cycle write request to the byte controller.
REQ-013 device_id  out  8  constant DEV_ID.
REQ-014 reg_addr  out  16  register address of the current entry.
REQ-015 addr_mode  out  1  constant ADDR16.
REQ-016 wr_data  out  8  data byte of the current entry.
REQ-017 w_num  out  6  constant 6'd1.
REQ-018 wr_done  in  1  one-cycle pulse from the controller when the transfer ends.
REQ-019 ack  in  1  sampled with wr_done; 1 = NACK seen (failure).
REQ-020 busy  out  1  high from start acceptance until DONE or ERR exits.
REQ-021 cfg_ok  out  1  level; set on successful completion, cleared on next accepted start.
REQ-022 err  out  1  level; set on abort, cleared on next accepted start.
REQ-023 err_idx  out  8  index of the failing entry, valid while err=1.

Function
REQ-024 The FSM SHALL have states IDLE, DELAY, FETCH, LATCH, ISSUE, WAIT, DONE, ERR.
REQ-025 IDLE: start=1 accepted -> DELAY; capture tbl_len; clear cfg_ok, err, index, and retry count; start while busy=1 is ignored.
REQ-026 DELAY: count PWR_DLY cycles, then -> FETCH; if the captured tbl_len=0 -> DONE instead.
REQ-027 FETCH: drive tbl_addr=index for one cycle -> LATCH.
REQ-028 LATCH: register reg_addr=tbl_data[23:8] and wr_data=tbl_data[7:0] -> ISSUE.
REQ-029 ISSUE: w_req=1 for exactly one cycle; clear watchdog -> WAIT.
REQ-030 WAIT: on wr_done=1 with ack=0 -> clear retry count; last index (tbl_len-1) -> DONE, else increment index -> FETCH.
REQ-031 WAIT: on wr_done=1 with ack=1, or watchdog reaching TIMEOUT -> if retry count < RETRY_MAX, increment it and -> ISSUE with the same latched entry; else err_idx=index -> ERR.
REQ-032 WAIT: a wr_done that coincides with the watchdog reaching TIMEOUT SHALL be treated as wr_done.
REQ-033 DONE: cfg_ok<=1, busy<=0 -> IDLE, one cycle.
REQ-034 ERR: err<=1, busy<=0 -> IDLE, one cycle; no further w_req is issued.
REQ-035 reg_addr, wr_data, and tbl_addr SHALL be held stable from LATCH until the next FETCH.
REQ-036 Index SHALL never exceed tbl_len-1; no wrap.
REQ-037 Exactly one w_req SHALL be issued per attempt; total attempts per entry <= RETRY_MAX+1.

Reset
REQ-038 When rst_n=0, the block SHALL enter IDLE, regardless of current state, including a mid-transfer WAIT.
REQ-039 During reset, all outputs SHALL be 0 except device_id=DEV_ID, addr_mode=ADDR16, w_num=1; counters SHALL be 0.

Verification
REQ-040 PWR_DLY=4, tbl_len=3, ROM {0x3008_82, 0x3103_03, 0x3017_FF}, always ack=0 -> three w_req with matching reg_addr/wr_data, cfg_ok=1, err=0.
REQ-041 tbl_len=2; entry 1 returns NACK twice then ACK -> 4 w_req total, entry 1 repeated with the same data, cfg_ok=1.
REQ-042 RETRY_MAX=3; entry 0 always NACKs -> exactly 4 w_req, err=1, err_idx=0, busy=0, cfg_ok=0.
REQ-043 TIMEOUT=16; wr_done is never returned -> retries at 16-cycle spacing, then err=1.
REQ-044 tbl_len=0 -> no w_req, cfg_ok=1 after PWR_DLY+1 cycles; a second start during busy has no effect.
REQ-045 rst_n asserted during WAIT -> all outputs reset immediately; a new start restarts from index 0.

Source files
------------

// File: rtl/iic_cfg_seq.sv
// Walks a register/data table held in an external ROM and writes each entry to an
// I2C device through a byte controller, with per-entry retries and a response watchdog.
module iic_cfg_seq #(
    parameter logic [7:0]  DEV_ID    = 8'hA0,
    parameter bit          ADDR16    = 1'b1,
    parameter int unsigned PWR_DLY   = 1000,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  tbl_len,
    output logic [7:0]  tbl_addr,
    input  logic [23:0] tbl_data,
    output logic        w_req,
    output logic [7:0]  device_id,
    output logic [15:0] reg_addr,
    output logic        addr_mode,
    output logic [7:0]  wr_data,
    output logic [5:0]  w_num,
    input  logic        wr_done,
    input  logic        ack,
    output logic        busy,
    output logic        cfg_ok,
    output logic        err,
    output logic [7:0]  err_idx
);

    localparam int DLY_W = (PWR_DLY > 2) ? $clog2(PWR_DLY) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, DELAY, FETCH, LATCH, ISSUE, WAIT, DONE, ERR
    } state_t;

    state_t           state;
    logic [7:0]       len;
    logic [7:0]       idx;
    logic [DLY_W-1:0] dly_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [RTY_W-1:0] retry_cnt;

    logic delay_over;
    logic wd_expired;
    logic last_entry;
    logic can_retry;

    assign device_id = DEV_ID;
    assign addr_mode = ADDR16;
    assign w_num     = 6'd1;

    // The watchdog restarts on the w_req cycle, so it measures cycles since the request.
    assign delay_over = (32'(dly_cnt) + 32'd1) >= PWR_DLY;
    assign wd_expired = (32'(wd_cnt) + 32'd1) >= TIMEOUT;
    assign last_entry = 8'(idx + 8'd1) == len;
    assign can_retry  = 32'(retry_cnt) < RETRY_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            dly_cnt   <= '0;
            wd_cnt    <= '0;
            retry_cnt <= '0;
            tbl_addr  <= '0;
            reg_addr  <= '0;
            wr_data   <= '0;
            w_req     <= 1'b0;
            busy      <= 1'b0;
            cfg_ok    <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
        end else begin
            w_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DELAY;
                        busy      <= 1'b1;
                        cfg_ok    <= 1'b0;
                        err       <= 1'b0;
                        err_idx   <= '0;
                        len       <= tbl_len;
                        idx       <= '0;
                        tbl_addr  <= '0;
                        retry_cnt <= '0;
                        dly_cnt   <= '0;
                    end
                end
                DELAY: begin
                    if (delay_over) begin
                        state <= (len == 8'd0) ? DONE : FETCH;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    reg_addr <= tbl_data[23:8];
                    wr_data  <= tbl_data[7:0];
                    w_req    <= 1'b1;
                    wd_cnt   <= '0;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    state  <= WAIT;
                end
                WAIT: begin
                    // A completion in the same cycle as the watchdog expiry wins.
                    if (wr_done && !ack) begin
                        retry_cnt <= '0;
                        if (last_entry) begin
                            state <= DONE;
                        end else begin
                            idx      <= idx + 8'd1;
                            tbl_addr <= idx + 8'd1;
                            state    <= FETCH;
                        end
                    end else if (wr_done || wd_expired) begin
                        if (can_retry) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            w_req     <= 1'b1;
                            wd_cnt    <= '0;
                            state     <= ISSUE;
                        end else begin
                            err_idx <= idx;
                            state   <= ERR;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    cfg_ok <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Self-checking bench for iic_cfg_seq: ROM and byte-controller models, table-driven
// scenarios, hand-written corner sequences and randomized runs against a table-walk model.
module tb_iic_cfg_seq;

    localparam int PWR_DLY   = 4;
    localparam int RETRY_MAX = 3;
    localparam int TIMEOUT   = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  tbl_len;
    logic [7:0]  tbl_addr;
    logic [23:0] tbl_data;
    logic        w_req;
    logic [7:0]  device_id;
    logic [15:0] reg_addr;
    logic        addr_mode;
    logic [7:0]  wr_data;
    logic [5:0]  w_num;
    logic        wr_done;
    logic        ack;
    logic        busy;
    logic        cfg_ok;
    logic        err;
    logic [7:0]  err_idx;

    iic_cfg_seq #(
        .DEV_ID   (8'hA0),
        .ADDR16   (1'b1),
        .PWR_DLY  (PWR_DLY),
        .RETRY_MAX(RETRY_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tbl_len  (tbl_len),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .w_req    (w_req),
        .device_id(device_id),
        .reg_addr (reg_addr),
        .addr_mode(addr_mode),
        .wr_data  (wr_data),
        .w_num    (w_num),
        .wr_done  (wr_done),
        .ack      (ack),
        .busy     (busy),
        .cfg_ok   (cfg_ok),
        .err      (err),
        .err_idx  (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat: cycles from the w_req cycle to the wr_done cycle; lat <= 0 means no reply.
    typedef struct {
        int lat;
        bit nack;
    } resp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] reg_a;
        logic [7:0]  data;
        int          cyc;
    } wreq_t;

    typedef struct {
        logic [7:0] len;
        int         fail_entry;
        int         fail_cnt;
        bit         to_mode;
        int         exp_wreq;
        bit         exp_ok;
        logic [7:0] exp_err_idx;
    } vec_t;

    logic [23:0] rom [256];
    resp_t       plan [4096];
    wreq_t       wlog [4096];
    int          exp_idx [256];
    int          wreq_total;
    int          resp_cnt;
    bit          cur_nack;
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always @(posedge clk) tbl_data <= rom[tbl_addr];
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-controller model: logs every request and answers according to plan[].
    initial begin
        wreq_total = 0;
        resp_cnt   = 0;
        cur_nack   = 1'b0;
        wr_done    = 1'b0;
        ack        = 1'b0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0;
            ack     = 1'b0;
            if (!rst_n) begin
                resp_cnt = 0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    wr_done = 1'b1;
                    ack     = cur_nack;
                end
            end
            if (rst_n && w_req && wreq_total < 4095) begin
                wlog[wreq_total] = '{tbl_addr, reg_addr, wr_data, cyc};
                resp_cnt         = plan[wreq_total].lat;
                cur_nack         = plan[wreq_total].nack;
                wreq_total++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Walks the table entry by entry, consuming one planned reply per attempt.
    task automatic modelRun(input int len, input int base, output int n_att, output bit ok, output int eidx);
        int  tries;
        bit  fin;
        bit  good;
        n_att = 0;
        ok    = 1'b1;
        eidx  = 0;
        for (int e = 0; e < len && ok; e++) begin
            tries = 0;
            fin   = 1'b0;
            while (!fin) begin
                exp_idx[n_att] = e;
                good = plan[base + n_att].lat >= 1 && plan[base + n_att].lat <= TIMEOUT - 1
                       && !plan[base + n_att].nack;
                n_att++;
                if (good) begin
                    fin = 1'b1;
                end else begin
                    tries++;
                    if (tries > RETRY_MAX) begin
                        ok   = 1'b0;
                        eidx = e;
                        fin  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] len);
        int n;
        @(negedge clk);
        tbl_len = len;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run_terminates", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic runAndCheck(input logic [7:0] len, input int exp_cnt, input bit exp_ok, input logic [7:0] exp_eidx);
        int base;
        int n_att;
        int got;
        bit m_ok;
        int m_eidx;
        base = wreq_total;
        modelRun(int'(len), base, n_att, m_ok, m_eidx);
        applyStimulus(len);
        got = wreq_total - base;
        checkOutput("wreq_count", got, exp_cnt);
        for (int k = 0; k < got && k < n_att; k++) begin
            checkOutput("wreq_entry",
                        {wlog[base + k].addr, wlog[base + k].reg_a, wlog[base + k].data},
                        {exp_idx[k][7:0], rom[exp_idx[k]]});
        end
        checkOutput("cfg_ok", {31'b0, cfg_ok}, {31'b0, exp_ok});
        checkOutput("err", {31'b0, err}, {31'b0, !exp_ok});
        if (!exp_ok) checkOutput("err_idx", {24'b0, err_idx}, {24'b0, exp_eidx});
    endtask

    task automatic buildPlan(input vec_t v);
        int base;
        int k;
        base = wreq_total;
        k    = 0;
        for (int e = 0; e < int'(v.len); e++) begin
            if (e == v.fail_entry) begin
                for (int j = 0; j < v.fail_cnt; j++) begin
                    plan[base + k] = v.to_mode ? '{-1, 1'b0} : '{2 + j % 4, 1'b1};
                    k++;
                end
            end
            plan[base + k] = '{1 + k % 5, 1'b0};
            k++;
        end
    endtask

    vec_t vecs [8];

    initial begin
        int base;
        int first;
        int n_att;
        int m_eidx;
        int r;
        int n;
        bit m_ok;
        logic [7:0] rl;

        vecs[0] = '{8'd3, -1, 0, 1'b0, 3, 1'b1, 8'd0};
        vecs[1] = '{8'd2,  1, 2, 1'b0, 4, 1'b1, 8'd0};
        vecs[2] = '{8'd2,  0, 8, 1'b0, 4, 1'b0, 8'd0};
        vecs[3] = '{8'd0, -1, 0, 1'b0, 0, 1'b1, 8'd0};
        vecs[4] = '{8'd3,  2, 3, 1'b0, 6, 1'b1, 8'd0};
        vecs[5] = '{8'd3,  1, 4, 1'b0, 5, 1'b0, 8'd1};
        vecs[6] = '{8'd1,  0, 8, 1'b1, 4, 1'b0, 8'd0};
        vecs[7] = '{8'd3,  1, 1, 1'b1, 4, 1'b1, 8'd0};

        for (int i = 0; i < 256; i++) rom[i] = 24'h0;
        rom[0] = 24'h3008_82;
        rom[1] = 24'h3103_03;
        rom[2] = 24'h3017_FF;

        rst_n   = 1'b0;
        start   = 1'b0;
        tbl_len = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ctrl", {28'b0, busy, w_req, cfg_ok, err}, 32'd0);
        checkOutput("rst_data", {tbl_addr, reg_addr, wr_data}, 32'd0);
        checkOutput("rst_err_idx", {24'b0, err_idx}, 32'd0);
        checkOutput("const_outputs", {17'b0, device_id, addr_mode, w_num}, {17'b0, 8'hA0, 1'b1, 6'd1});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            buildPlan(vecs[i]);
            runAndCheck(vecs[i].len, vecs[i].exp_wreq, vecs[i].exp_ok, vecs[i].exp_err_idx);
        end

        // Watchdog-only retries are spaced TIMEOUT cycles apart.
        base = wreq_total;
        for (int k = 0; k < 4; k++) plan[base + k] = '{-1, 1'b0};
        runAndCheck(8'd1, 4, 1'b0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("timeout_spacing", wlog[base + k + 1].cyc - wlog[base + k].cyc, TIMEOUT);
        end

        // Reply landing in the watchdog's final cycle counts as a completion.
        base = wreq_total;
        plan[base] = '{TIMEOUT - 1, 1'b0};
        runAndCheck(8'd1, 1, 1'b1, 8'd0);

        // Empty table: cfg_ok after PWR_DLY+1 cycles; a start while busy is ignored.
        base  = wreq_total;
        first = -1;
        @(negedge clk);
        tbl_len = 8'd0;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                tbl_len = 8'd3;
                start   = 1'b1;
            end
            if (c == 3) start = 1'b0;
            if (cfg_ok && first < 0) first = c;
        end
        checkOutput("len0_cfg_ok_cycle", first, PWR_DLY + 1);
        checkOutput("len0_no_wreq", wreq_total - base, 0);
        checkOutput("len0_idle", {30'b0, busy, err}, 32'd0);

        // Reset while waiting on entry 1, then a clean restart from entry 0.
        base = wreq_total;
        plan[base]     = '{3, 1'b0};
        plan[base + 1] = '{-1, 1'b0};
        @(negedge clk);
        tbl_len = 8'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (wreq_total < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("second_wreq_seen", wreq_total - base, 2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ctrl", {28'b0, busy, w_req, cfg_ok, err}, 32'd0);
        checkOutput("rst_mid_data", {tbl_addr, reg_addr, wr_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wreq_total;
        for (int k = 0; k < 3; k++) plan[base + k] = '{2, 1'b0};
        runAndCheck(8'd3, 3, 1'b1, 8'd0);

        // Randomized tables and controller behaviour.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 8; i++) rom[i] = 24'($urandom);
            base = wreq_total;
            for (int k = 0; k < 64; k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 65)      plan[base + k] = '{int'($urandom_range(1, TIMEOUT - 2)), 1'b0};
                else if (r < 75) plan[base + k] = '{TIMEOUT - 1, 1'b0};
                else if (r < 90) plan[base + k] = '{int'($urandom_range(1, TIMEOUT - 1)), 1'b1};
                else             plan[base + k] = '{-1, 1'b0};
            end
            rl = 8'($urandom_range(1, 6));
            modelRun(int'(rl), base, n_att, m_ok, m_eidx);
            runAndCheck(rl, n_att, m_ok, 8'(m_eidx));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
